// File: rtl/lit_array.sv
// Clause evaluator over a store of NUM_LITS 3-bit literals: reports sat/unit/conflict and can write back the implied literal.
// Optional build macro CCLAUSE_CNT_EN adds an 8-bit saturating conflict counter output (cclause_cnt_o).
module lit_array #(
  parameter int NUM_LITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic [NUM_LITS*3-1:0] var_value_frombase_i,
  output logic [NUM_LITS*3-1:0] var_value_tobase_o,
  input  logic                  eval_i,
  input  logic                  imp_drv_i,
  input  logic                  cclause_drv_i,
  output logic                  valid_o,
  output logic [1:0]            freelitcnt_o,
  output logic                  clausesat_o,
  output logic                  cclause_o,
  output logic                  unit_o,
  output logic [((NUM_LITS > 2) ? $clog2(NUM_LITS) : 1)-1:0] imp_idx_o
`ifdef CCLAUSE_CNT_EN
  ,
  output logic [7:0]            cclause_cnt_o
`endif
);

  localparam int IDX_W = (NUM_LITS > 2) ? $clog2(NUM_LITS) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, REPORT, IMPLY} state_t;

  state_t             state_reg, state_next;
  logic               load_en, imply_en;
  logic               any_true, any_present, found_free;
  logic [1:0]         free_cnt;
  logic [IDX_W-1:0]   first_free;
  logic               sat_reg, unit_reg, cclause_reg;
  logic [1:0]         free_reg;
  logic [IDX_W-1:0]   idx_reg;

  // Each literal is its own register so the load and the implied write never share a driver.
  for (genvar gi = 0; gi < NUM_LITS; gi++) begin : g_lit
    logic [2:0] lit_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        lit_reg <= 3'b000;
      end else if (load_en) begin
        lit_reg <= var_value_frombase_i[(NUM_LITS-1-gi)*3 +: 3];
      end else if (imply_en && (idx_reg == IDX_W'(gi))) begin
        lit_reg <= 3'b110;
      end
    end
    assign var_value_tobase_o[(NUM_LITS-1-gi)*3 +: 3] = lit_reg;
  end

  // Clause scan; the imp bit is irrelevant here, only val[1:0] matters.
  always_comb begin
    any_true    = 1'b0;
    any_present = 1'b0;
    found_free  = 1'b0;
    free_cnt    = 2'd0;
    first_free  = '0;
    for (int i = 0; i < NUM_LITS; i++) begin
      if (var_value_tobase_o[(NUM_LITS-1-i)*3 +: 2] == 2'b10) any_true = 1'b1;
      if (var_value_tobase_o[(NUM_LITS-1-i)*3 +: 2] != 2'b00) any_present = 1'b1;
      if (var_value_tobase_o[(NUM_LITS-1-i)*3 +: 2] == 2'b11) begin
        if (free_cnt != 2'd2) free_cnt = free_cnt + 2'd1;
        if (!found_free) first_free = IDX_W'(i);
        found_free = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    imply_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wr_i) load_en = 1'b1;
        else if (eval_i) state_next = EVAL;
      end
      EVAL:   state_next = REPORT;
      REPORT: begin
        if (unit_reg && imp_drv_i) begin
          state_next = IMPLY;
          imply_en   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      IMPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Status is captured at the end of EVAL so it is valid throughout REPORT and held afterwards.
  always_ff @(posedge clk) begin
    if (rst || load_en) begin
      sat_reg     <= 1'b0;
      unit_reg    <= 1'b0;
      cclause_reg <= 1'b0;
      free_reg    <= 2'd0;
      idx_reg     <= '0;
    end else if (state_reg == EVAL) begin
      sat_reg     <= any_true;
      free_reg    <= free_cnt;
      unit_reg    <= !any_true && (free_cnt == 2'd1);
      idx_reg     <= (!any_true && (free_cnt == 2'd1)) ? first_free : '0;
      cclause_reg <= !any_true && (free_cnt == 2'd0) && any_present;
    end else if (cclause_drv_i && cclause_reg) begin
      cclause_reg <= 1'b0;
    end
  end

  assign valid_o      = (state_reg == REPORT);
  assign clausesat_o  = sat_reg;
  assign unit_o       = unit_reg;
  assign cclause_o    = cclause_reg;
  assign freelitcnt_o = free_reg;
  assign imp_idx_o    = idx_reg;

`ifdef CCLAUSE_CNT_EN
  logic [7:0] cnt_reg;
  always_ff @(posedge clk) begin
    if (rst || load_en) begin
      cnt_reg <= 8'd0;
    end else if ((state_reg == REPORT) && cclause_reg && (cnt_reg != 8'hFF)) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end
  assign cclause_cnt_o = cnt_reg;
`endif

endmodule
